load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Initiator side of the byte-masked data-memory port: accepts one load/store request from the core.
//   Drives word address, lane-shifted write data and 4-bit write mask into the data memory; memory reads combinationally.
//   Splits misaligned accesses into two word beats. Returns extended load data or a completion pulse.
// PARAMETERS
//   SPLIT_EN  1  1: misaligned access done as two beats; 0: misaligned -> resp_err, no memory access
// PORTS
//   clk         in   1   clock, all state updates on posedge
//   reset       in   1   synchronous, active-high reset
//   req_valid   in   1   request present
//   req_ready   out  1   unit idle, request accepted when req_valid&req_ready
//   req_store   in   1   1=store, 0=load
//   req_funct3  in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (RV32I encoding)
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data, right-justified
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out  32  extended load data; 0 for stores and errors
//   resp_err    out  1   valid with resp_valid: illegal funct3, or misaligned with SPLIT_EN=0
//   mem_a       out  32  word-aligned byte address to memory, bits[1:0]=00
//   mem_wd      out  32  lane-positioned write data
//   mem_wmask   out  4   byte write enables, bit i -> bits[8i+7:8i]
//   mem_rd      in   32  combinational read data for mem_a
// BEHAVIOUR
//   Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0; resp_rdata=0; mem_a=0, mem_wd=0, mem_wmask=0.
//   Request is registered on acceptance. mem_* are functions of registered state only, never of req_* directly.
//   FSM: IDLE -(accept)-> BEAT0 -(split)-> BEAT1 -> RESP -> IDLE; BEAT0 -> RESP when not split.
//     Error requests go IDLE -> RESP directly. No memory cycle occurs, so mem_wmask stays 0.
//   req_ready=1 only in IDLE; req_valid in other states is ignored and not queued.
//   Sizes: n=1,2,4 bytes; o=addr[1:0]; split when o+n>4 (H at o=3; W at o=1..3).
//   BEAT0: mem_a={addr[31:2],00}; mem_wmask=((2^n-1)<<o)[3:0] if store, else 0; mem_wd=wdata<<8o.
//   BEAT1: mem_a={addr[31:2]+1,00}, modulo 2^32 (0xFFFFFFFC wraps to 0).
//     mem_wmask=((2^n-1)<<o)>>4 if store, else 0; mem_wd=wdata>>8(4-o).
//   Loads: mem_rd captured at end of BEAT0 (rd0) and BEAT1 (rd1, 0 if not split).
//     Result = ({rd1,rd0}>>8o) truncated to n bytes.
//     Sign-extended for B/H, zero-extended for BU/HU; W passes through.
//   Stores to funct3 BU/HU (100/101) are illegal -> resp_err.
//   Latency: accept at edge k; BEAT0 cycle k+1; resp_valid in cycle k+2 aligned, k+3 split, k+1 error.
//   Next request is accepted in the cycle after RESP (req_ready high again in IDLE).
//   resp_rdata/resp_err hold their value until the next RESP. resp_valid is high exactly one cycle.
//   Stores take effect at the memory on the clock edge ending each beat.
//   Reset mid-operation: return to IDLE next edge, no resp_valid.
//     A split store reset after BEAT0 leaves beat-0 bytes written. This is intended; the core does not retry.
// TESTING
//   Mem[0]=0x8899AABB. LB addr 0x1 -> resp_rdata 0xFFFFFFAA, resp_valid at k+2, mem_wmask always 0.
//   LHU addr 0x2 on the same word -> 0x00008899. LW addr 0x0 -> 0x8899AABB.
//   SB 0x000000EE at addr 0x6 -> single beat at mem_a 0x4, mem_wmask 0100, mem_wd 0x00EE0000.
//   SW 0x11223344 at 0x3 -> BEAT0 a=0x0 mask 1000 wd 0x44000000; BEAT1 a=0x4 mask 0111 wd 0x00112233; resp_valid at k+3.
//   LW at 0x3 after that store -> 0x11223344.
//   LH at 0xFFFFFFFF -> BEAT1 mem_a=0x00000000. funct3=011 -> resp_err=1 at k+1, no mem_wmask activity.
//   SPLIT_EN=0 with LW at 0x2 -> resp_err, no access.
//   Assert reset during BEAT1 of a split store -> IDLE, req_ready=1, no resp_valid, only beat-0 bytes changed.
//   req_valid held high throughout -> back-to-back acceptance every 3 cycles for aligned ops.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-masked, combinational-read data memory.
// Word-crossing accesses are either split into two beats or rejected, depending on SPLIT_EN.
module load_store_unit #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t      state, state_nx;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rd0_q;

  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] o, input logic [1:0] sz);
    crosses = ({1'b0, o} + size_of(sz)) > 3'd4;
  endfunction

  // Incoming decode: only used to pick the error path at acceptance.
  logic accept, req_illegal, req_err;
  assign accept      = req_valid & req_ready;
  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_store && req_funct3[2]);
  assign req_err     = req_illegal || (!SPLIT_EN && crosses(req_addr[1:0], req_funct3[1:0]));

  // Registered-request lane placement, shared by both beats.
  logic [1:0]  off;
  logic [3:0]  bmask;
  logic [7:0]  m8;
  logic [63:0] wd64;
  logic        split_q;

  assign off     = addr_q[1:0];
  assign split_q = crosses(off, f3_q[1:0]);
  assign bmask   = (f3_q[1:0] == 2'b00) ? 4'b0001 :
                   (f3_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
  assign m8      = {4'b0000, bmask} << off;
  assign wd64    = {32'h0, wdata_q} << {off, 3'b000};

  // Load assembly: at the end of BEAT1 the live read is the upper word.
  logic [31:0] lo_w, hi_w, shifted, load_res;
  logic [63:0] rd64;

  assign lo_w    = (state == BEAT1) ? rd0_q  : mem_rd;
  assign hi_w    = (state == BEAT1) ? mem_rd : 32'h0;
  assign rd64    = {hi_w, lo_w} >> {off, 3'b000};
  assign shifted = rd64[31:0];

  always_comb begin
    case (f3_q)
      3'b000:  load_res = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_res = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_res = {24'h0, shifted[7:0]};
      3'b101:  load_res = {16'h0, shifted[15:0]};
      default: load_res = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      st_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rd0_q      <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        st_q    <= req_store;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == BEAT0) rd0_q <= mem_rd;
      if (state_nx == RESP && state != RESP) begin
        resp_err   <= (state == IDLE) ? req_err : 1'b0;
        resp_rdata <= (state == IDLE || st_q) ? 32'h0 : load_res;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = req_err ? RESP : BEAT0;
      BEAT0:   state_nx = split_q ? BEAT1 : RESP;
      BEAT1:   state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // Write enables are suppressed while reset is high so an interrupted beat never lands.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_a      = 32'h0;
    mem_wd     = 32'h0;
    mem_wmask  = 4'b0000;
    case (state)
      BEAT0: begin
        mem_a  = {addr_q[31:2], 2'b00};
        mem_wd = wd64[31:0];
        if (st_q && !reset) mem_wmask = m8[3:0];
      end
      BEAT1: begin
        mem_a  = {addr_q[31:2] + 30'd1, 2'b00};
        mem_wd = wd64[63:32];
        if (st_q && !reset) mem_wmask = m8[7:4];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: split and unsplit instances against a small word memory.
module tb_load_store_unit;

  logic        clk, reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
  logic [3:0]  mem_wmask;

  logic        r2_valid, r2_ready, r2_store, r2_resp_valid, r2_err;
  logic [2:0]  r2_f3;
  logic [31:0] r2_addr, r2_wdata, r2_rdata, r2_a, r2_wd;
  logic [3:0]  r2_wmask;

  int n_chk, n_pass;

  load_store_unit #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_a(mem_a), .mem_wd(mem_wd), .mem_wmask(mem_wmask),
    .mem_rd(mem_rd));

  load_store_unit #(.SPLIT_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_store(r2_store), .req_funct3(r2_f3), .req_addr(r2_addr),
    .req_wdata(r2_wdata), .resp_valid(r2_resp_valid), .resp_rdata(r2_rdata),
    .resp_err(r2_err), .mem_a(r2_a), .mem_wd(r2_wd), .mem_wmask(r2_wmask),
    .mem_rd(32'h0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16-word memory, backdoor preload port shares the write process.
  logic [31:0] mem [16];
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_val;

  assign mem_rd = mem[mem_a[5:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_val;
    else for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem[mem_a[5:2]][8*b +: 8] <= mem_wd[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic bd_write(input logic [3:0] idx, input logic [31:0] val);
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    tick;
    bd_we = 1'b0;
  endtask

  logic [31:0] bt_a [2];
  logic [31:0] bt_wd [2];
  logic [3:0]  bt_m [2];

  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                     output logic err, output logic [3:0] mask_or);
    int w;
    bt_a[0] = 'x; bt_a[1] = 'x; bt_m[0] = 'x; bt_m[1] = 'x; bt_wd[0] = 'x; bt_wd[1] = 'x;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 10) begin tick; w++; end
    if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
    tick;
    req_valid = 1'b0;
    lat = 0; mask_or = 4'b0; rdata = 'x; err = 1'bx;
    while (lat < 10) begin
      lat++;
      mask_or |= mem_wmask;
      if (resp_valid) begin
        rdata = resp_rdata; err = resp_err;
        break;
      end
      if (lat <= 2) begin
        bt_a[lat-1] = mem_a; bt_m[lat-1] = mem_wmask; bt_wd[lat-1] = mem_wd;
      end
      tick;
    end
    if (!resp_valid) chk("resp_timeout", 32'h0, 32'h1);
  endtask

  int          lat, acc, nresp;
  logic [31:0] rd;
  logic        er;
  logic [3:0]  mo;

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    r2_valid = 1'b0; r2_store = 1'b0; r2_f3 = 3'b0; r2_addr = 32'h0; r2_wdata = 32'h0;
    bd_we = 1'b0; bd_idx = 4'h0; bd_val = 32'h0;
    tick;
    for (int i = 0; i < 16; i++) bd_write(i[3:0], 32'h0);
    bd_write(4'd0, 32'h8899AABB);
    bd_write(4'd15, 32'hAB000000);
    reset = 1'b0;
    tick;

    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_wmask", {28'h0, mem_wmask}, 32'h0);

    run(1'b0, 3'b000, 32'h1, 32'h0, lat, rd, er, mo);
    chk("lb_data", rd, 32'hFFFFFFAA);
    chk("lb_lat", lat, 2);
    chk("lb_wmask", {28'h0, mo}, 32'h0);
    chk("lb_mem_a", bt_a[0], 32'h0);

    run(1'b0, 3'b101, 32'h2, 32'h0, lat, rd, er, mo);
    chk("lhu_data", rd, 32'h00008899);

    run(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, er, mo);
    chk("lw_data", rd, 32'h8899AABB);
    chk("lw_err", {31'h0, er}, 32'h0);

    run(1'b1, 3'b000, 32'h6, 32'h000000EE, lat, rd, er, mo);
    chk("sb_a", bt_a[0], 32'h4);
    chk("sb_mask", {28'h0, bt_m[0]}, 32'h4);
    chk("sb_wd", bt_wd[0], 32'h00EE0000);
    chk("sb_lat", lat, 2);
    chk("sb_rdata", rd, 32'h0);
    chk("sb_mem1", mem[1], 32'h00EE0000);

    run(1'b1, 3'b010, 32'h3, 32'h11223344, lat, rd, er, mo);
    chk("sw_b0_a", bt_a[0], 32'h0);
    chk("sw_b0_mask", {28'h0, bt_m[0]}, 32'h8);
    chk("sw_b0_wd", bt_wd[0], 32'h44000000);
    chk("sw_b1_a", bt_a[1], 32'h4);
    chk("sw_b1_mask", {28'h0, bt_m[1]}, 32'h7);
    chk("sw_b1_wd", bt_wd[1], 32'h00112233);
    chk("sw_lat", lat, 3);
    chk("sw_mem0", mem[0], 32'h4499AABB);
    chk("sw_mem1", mem[1], 32'h00112233);

    run(1'b0, 3'b010, 32'h3, 32'h0, lat, rd, er, mo);
    chk("lw3_data", rd, 32'h11223344);
    chk("lw3_lat", lat, 3);

    run(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, lat, rd, er, mo);
    chk("lh_wrap_b0_a", bt_a[0], 32'hFFFFFFFC);
    chk("lh_wrap_b1_a", bt_a[1], 32'h0);
    chk("lh_wrap_data", rd, 32'hFFFFBBAB);

    run(1'b1, 3'b011, 32'h0, 32'hDEADBEEF, lat, rd, er, mo);
    chk("f3_011_err", {31'h0, er}, 32'h1);
    chk("f3_011_lat", lat, 1);
    chk("f3_011_wmask", {28'h0, mo}, 32'h0);
    chk("f3_011_rdata", rd, 32'h0);
    chk("f3_011_mem0", mem[0], 32'h4499AABB);

    run(1'b1, 3'b100, 32'h0, 32'h0, lat, rd, er, mo);
    chk("sbu_err", {31'h0, er}, 32'h1);
    tick;
    chk("err_hold", {31'h0, resp_err}, 32'h1);

    // Unsplit instance rejects a word-crossing load without touching memory.
    r2_valid = 1'b1; r2_f3 = 3'b010; r2_addr = 32'h2;
    chk("ns_ready", {31'h0, r2_ready}, 32'h1);
    tick;
    r2_valid = 1'b0;
    chk("ns_resp_valid", {31'h0, r2_resp_valid}, 32'h1);
    chk("ns_err", {31'h0, r2_err}, 32'h1);
    chk("ns_wmask", {28'h0, r2_wmask}, 32'h0);
    tick;

    // Reset during BEAT1 of a split store: beat 0 lands, beat 1 does not.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h9; req_wdata = 32'hCAFEBABE;
    while (!req_ready) tick;
    tick;
    req_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rmid_ready", {31'h0, req_ready}, 32'h1);
    nresp = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) nresp++;
      tick;
    end
    chk("rmid_no_resp", nresp, 0);
    chk("rmid_mem2", mem[2], 32'hFEBABE00);
    chk("rmid_mem3", mem[3], 32'h0);

    // Held request: aligned accepts every 3 cycles.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    acc = 0; nresp = 0;
    for (int i = 0; i < 9; i++) begin
      if (req_valid && req_ready) acc++;
      if (resp_valid) nresp++;
      tick;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc, 3);
    chk("b2b_resps", nresp, 3);
    chk("b2b_rdata", resp_rdata, 32'h4499AABB);
    tick; tick; tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
